// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// One operation in flight: IDLE accepts, EXEC samples the ALU, RESP holds the response.
module alu_arbiter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_opcode,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_opcode,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic [W-1:0] alu_opcode,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_result,
  input  logic [3:0]   alu_flags,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_result,
  output logic [3:0]   rsp_flags,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   ptr;
  logic   op_id;

  // Grant: a lone requester wins; on contention the pointer picks the winner.
  assign req0_ready = (state == IDLE) && req0_valid && (!req1_valid || !ptr);
  assign req1_ready = (state == IDLE) && req1_valid && (!req0_valid || ptr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      op_id      <= 1'b0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready) begin
            alu_opcode <= req0_opcode;
            alu_a      <= req0_a;
            alu_b      <= req0_b;
            op_id      <= 1'b0;
            ptr        <= 1'b1;
            busy       <= 1'b1;
            state      <= EXEC;
          end else if (req1_ready) begin
            alu_opcode <= req1_opcode;
            alu_a      <= req1_a;
            alu_b      <= req1_b;
            op_id      <= 1'b1;
            ptr        <= 1'b0;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_flags  <= alu_flags;
          rsp_id     <= op_id;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: table vectors, arbitration/stall/reset sequences,
// and random transactions against an integer-arithmetic reference of the shared ALU.
module tb_alu_arbiter;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_opcode, req0_a, req0_b, req1_opcode, req1_a, req1_b;
  logic [W-1:0] alu_opcode, alu_a, alu_b, alu_result;
  logic [3:0]   alu_flags;
  logic         rsp_valid, rsp_ready, rsp_id, busy;
  logic [W-1:0] rsp_result;
  logic [3:0]   rsp_flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
  );

  // Shared ALU + flag calculator: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, else pass a.
  logic [W:0] alu_sum;
  always_comb begin
    alu_sum    = '0;
    alu_result = alu_a;
    alu_flags  = '0;
    case (alu_opcode)
      4'd0: begin
        alu_sum      = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = alu_sum[W-1:0];
        alu_flags[1] = alu_sum[W];
        alu_flags[0] = (alu_a[W-1] == alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
      end
      4'd1: begin
        alu_sum      = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
        alu_result   = alu_sum[W-1:0];
        alu_flags[1] = alu_sum[W];
        alu_flags[0] = (alu_a[W-1] != alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
      end
      4'd2: alu_result = alu_a & alu_b;
      4'd3: alu_result = alu_a | alu_b;
      4'd4: alu_result = alu_a ^ alu_b;
      default: alu_result = alu_a;
    endcase
    alu_flags[3] = alu_result[W-1];
    alu_flags[2] = (alu_result == '0);
  end

  // Reference: plain signed/unsigned integer arithmetic.
  function automatic int sgn(input int v);
    return (v > 7) ? v - 16 : v;
  endfunction

  task automatic ref_alu(input int op, input int a, input int b,
                         output logic [3:0] res, output logic [3:0] flg);
    int r, s, c, v;
    c = 0; v = 0;
    case (op)
      0: begin
        r = (a + b) % 16; c = (a + b > 15) ? 1 : 0;
        s = sgn(a) + sgn(b); v = (s > 7 || s < -8) ? 1 : 0;
      end
      1: begin
        r = (a - b + 16) % 16; c = (a >= b) ? 1 : 0;
        s = sgn(a) - sgn(b); v = (s > 7 || s < -8) ? 1 : 0;
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      default: r = a;
    endcase
    res = 4'(r);
    flg = {(r >= 8) ? 1'b1 : 1'b0, (r == 0) ? 1'b1 : 1'b0, 1'(c), 1'(v)};
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; invariants and stall stability checked after every edge.
  task automatic tick();
    logic         stall, pid;
    logic [W-1:0] pres;
    logic [3:0]   pflg;
    stall = rsp_valid && !rsp_ready;
    pres = rsp_result; pflg = rsp_flags; pid = rsp_id;
    @(posedge clk); #1;
    chk("ready_onehot", 32'(req0_ready && req1_ready), 0);
    if (busy) chk("ready_while_busy", {30'd0, req0_ready, req1_ready}, 0);
    if (stall) begin
      chk("stall_valid", 32'(rsp_valid), 1);
      chk("stall_result", 32'(rsp_result), 32'(pres));
      chk("stall_flags", 32'(rsp_flags), 32'(pflg));
      chk("stall_id", 32'(rsp_id), 32'(pid));
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) tick();
    chk("idle_timeout", 32'(busy), 0);
  endtask

  task automatic do_reset();
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    rst = 1; #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_outs", {alu_opcode, alu_a, alu_b, rsp_result, rsp_flags, 3'd0, rsp_id}, 0);
    @(posedge clk); #1;
    rst = 0;
  endtask

  // One transaction from requester sel, with `stall` cycles of response backpressure.
  task automatic do_txn(input bit sel, input logic [3:0] op, input logic [3:0] a,
                        input logic [3:0] b, input int stall,
                        input logic [3:0] exp_res, input logic [3:0] exp_flg);
    wait_idle();
    rsp_ready = (stall == 0);
    if (sel) begin
      req1_valid = 1; req1_opcode = op; req1_a = a; req1_b = b; req0_valid = 0;
    end else begin
      req0_valid = 1; req0_opcode = op; req0_a = a; req0_b = b; req1_valid = 0;
    end
    #1;
    chk("grant", {30'd0, req1_ready, req0_ready}, sel ? 32'd2 : 32'd1);
    tick();
    req0_valid = 0; req1_valid = 0;
    chk("exec_busy", 32'(busy), 1);
    chk("exec_no_rsp", 32'(rsp_valid), 0);
    chk("alu_drive", {alu_opcode, alu_a, alu_b}, {op, a, b});
    tick();
    chk("rsp_latency", 32'(rsp_valid), 1);
    chk("rsp_id", 32'(rsp_id), 32'(sel));
    chk("rsp_result", 32'(rsp_result), 32'(exp_res));
    chk("rsp_flags", 32'(rsp_flags), 32'(exp_flg));
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_busy", 32'(busy), 1);
    end
    rsp_ready = 1;
    tick();
    chk("rsp_release", 32'(rsp_valid), 0);
    chk("idle_busy", 32'(busy), 0);
  endtask

  typedef struct {
    bit         sel;
    logic [3:0] op, a, b, res, flg;
  } vec_t;

  vec_t tbl[8];
  int   grants[$];

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [3:0] er, ef;
    req0_opcode = 0; req0_a = 0; req0_b = 0;
    req1_opcode = 0; req1_a = 0; req1_b = 0;
    //           sel  op    a      b      res    flags {n,z,c,v}
    tbl[0] = '{1'b0, 4'd0, 4'h7, 4'h9, 4'h0, 4'b0110};
    tbl[1] = '{1'b1, 4'd1, 4'h3, 4'h5, 4'hE, 4'b1000};
    tbl[2] = '{1'b0, 4'd2, 4'hC, 4'hA, 4'h8, 4'b1000};
    tbl[3] = '{1'b1, 4'd3, 4'h5, 4'h2, 4'h7, 4'b0000};
    tbl[4] = '{1'b0, 4'd4, 4'hF, 4'hF, 4'h0, 4'b0100};
    tbl[5] = '{1'b1, 4'd0, 4'h7, 4'h1, 4'h8, 4'b1001};
    tbl[6] = '{1'b0, 4'd1, 4'h0, 4'h1, 4'hF, 4'b1000};
    tbl[7] = '{1'b1, 4'd1, 4'h8, 4'h1, 4'h7, 4'b0011};

    do_reset();
    for (int i = 0; i < 8; i++)
      do_txn(tbl[i].sel, tbl[i].op, tbl[i].a, tbl[i].b, 0, tbl[i].res, tbl[i].flg);

    // Contention from reset: alternating grants starting with requester 0.
    do_reset();
    req0_opcode = 4'd0; req0_a = 4'h1; req0_b = 4'h2;
    req1_opcode = 4'd1; req1_a = 4'h3; req1_b = 4'h5;
    req0_valid = 1; req1_valid = 1; #1;
    for (int cyc = 0; cyc < 40 && grants.size() < 4; cyc++) begin
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (rsp_valid && rsp_id) begin
        chk("cont_r1_result", 32'(rsp_result), 32'hE);
        chk("cont_r1_neg", 32'(rsp_flags[3]), 1);
      end
      if (rsp_valid && !rsp_id) chk("cont_r0_result", 32'(rsp_result), 32'h3);
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    chk("cont_grants", grants.size(), 4);
    for (int i = 0; i < grants.size(); i++) chk("cont_order", grants[i], i % 2);
    wait_idle();

    // Backpressure with both requesters pending.
    do_reset();
    do_txn(1'b0, 4'd1, 4'h3, 4'h5, 0, 4'hE, 4'b1000);
    req1_valid = 1; req1_opcode = 4'd4; req1_a = 4'h6; req1_b = 4'h3;
    rsp_ready = 0;
    #1;
    chk("bp_grant1", 32'(req1_ready), 1);
    tick();
    tick();
    req0_valid = 1; req0_opcode = 4'd0;
    chk("bp_rsp", {rsp_valid, rsp_id, rsp_result, rsp_flags}, {1'b1, 1'b1, 4'h5, 4'b0000});
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_busy", 32'(busy), 1);
      chk("bp_ready_low", {req0_ready, req1_ready}, 0);
    end
    rsp_ready = 1;
    req1_valid = 0;
    tick();
    chk("bp_release", 32'(rsp_valid), 0);
    #1;
    chk("bp_waiting_req0", 32'(req0_ready), 1);
    tick();
    req0_valid = 0;
    wait_idle();

    // Lone req1 with pointer at 0, then contention goes back to req0.
    do_reset();
    req1_valid = 1; req1_opcode = 4'd3; req1_a = 4'h1; req1_b = 4'h8;
    #1;
    chk("lone_r1_ready", {req0_ready, req1_ready}, 1);
    tick();
    req1_valid = 0;
    wait_idle();
    req0_valid = 1; req1_valid = 1; #1;
    chk("ptr_back_to_0", {req0_ready, req1_ready}, 2);
    tick();
    req0_valid = 0; req1_valid = 0;
    wait_idle();

    // Asynchronous reset mid-EXEC abandons the transaction.
    do_reset();
    req0_valid = 1; req0_opcode = 4'd0; req0_a = 4'h7; req0_b = 4'h9;
    #1;
    tick();
    req0_valid = 0;
    chk("pre_rst_busy", 32'(busy), 1);
    #2 rst = 1;
    #1;
    chk("async_rsp_valid", 32'(rsp_valid), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_outs", {alu_opcode, alu_a, alu_b, rsp_result, rsp_flags, 3'd0, rsp_id}, 0);
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("no_rsp_after_rst", 32'(rsp_valid), 0);
    end

    // Random transactions checked against the integer reference.
    for (int n = 0; n < 40; n++) begin
      int op, a, b, st;
      bit sel;
      sel = 1'($urandom_range(0, 1));
      op = $urandom_range(0, 5);
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      st = $urandom_range(0, 3);
      ref_alu(op, a, b, er, ef);
      do_txn(sel, 4'(op), 4'(a), 4'(b), st, er, ef);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
